calc_cmd_queue: RTL and testbench

Upstream command stage for the registered calculator (ALU + D flip-flop, 8-bit operands, 2-bit operation, 16-bit registered result Q).
- Buffers operand/operation commands from a producer through a valid/ready push interface in a DEPTH-entry FIFO.
- Issues at most one command per cycle to the calculator inputs.
- Tracks the calculator's one-cycle register latency, then captures Q and presents it as a single-cycle result strobe.

---
 rtl/calc_cmd_queue_if.sv | 37 +++
 rtl/calc_cmd_queue.sv | 102 ++++++++++
 tb/tb_calc_cmd_queue.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_cmd_queue_if.sv
// rtl/calc_cmd_queue_if.sv - push, issue and result signals of the calculator command queue
// master is the producer/calculator side, slave is the queue itself.
interface calc_cmd_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 2,
  parameter int RES_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_first;
  logic [DATA_W-1:0] in_second;
  logic [OP_W-1:0]   in_op;
  logic              issue_en;
  logic [DATA_W-1:0] first_num;
  logic [DATA_W-1:0] second_num;
  logic [OP_W-1:0]   operation;
  logic              out_valid;
  logic [RES_W-1:0]  calc_q;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_first, in_second, in_op, issue_en, calc_q,
    input  in_ready, first_num, second_num, operation, out_valid,
           res_valid, res_data, count
  );

  modport slave (
    input  in_valid, in_first, in_second, in_op, issue_en, calc_q,
    output in_ready, first_num, second_num, operation, out_valid,
           res_valid, res_data, count
  );
endinterface

// File: rtl/calc_cmd_queue.sv
// rtl/calc_cmd_queue.sv - command FIFO feeding the registered calculator, with result capture
// Issue is registered (no bypass); results are captured two edges after issue.
module calc_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 2,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  calc_cmd_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * DATA_W + OP_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] first_q, first_d;
  logic [DATA_W-1:0] second_q, second_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              out_valid_q, out_valid_d;
  logic              v2_q, v2_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              push;
  logic              pop;

  always_comb begin
    push        = bus.in_valid && (count_q < FULL_CNT);
    pop         = (count_q != '0) && bus.issue_en;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    first_d     = first_q;
    second_d    = second_q;
    op_d        = op_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_first, bus.in_second, bus.in_op};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      {first_d, second_d, op_d} = mem_q[rd_ptr_q];
      rd_ptr_d                  = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Calculator registers at issue+1; its Q is sampled one edge later.
    out_valid_d = pop;
    v2_d        = out_valid_q;
    res_valid_d = v2_q;
    res_data_d  = v2_q ? bus.calc_q : res_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      first_q     <= '0;
      second_q    <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      v2_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      first_q     <= first_d;
      second_q    <= second_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      v2_q        <= v2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.in_ready   = count_q < FULL_CNT;
  assign bus.count      = count_q;
  assign bus.first_num  = first_q;
  assign bus.second_num = second_q;
  assign bus.operation  = op_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
endmodule

// File: tb/tb_calc_cmd_queue.sv
// tb/tb_calc_cmd_queue.sv - randomized bench for calc_cmd_queue against a queue-based model
// A behavioural calculator closes the loop from first_num/second_num/operation to calc_q.
module tb_calc_cmd_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int OP_W   = 2;
  localparam int RES_W  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  calc_cmd_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W)) bus ();

  calc_cmd_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

  typedef struct {
    int          due;
    logic [15:0] val;
  } res_t;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] calc_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) bus.calc_q <= calc_fn(bus.first_num, bus.second_num, bus.operation);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending commands plus a list of results due on given cycles.
  cmd_t        mq[$];
  res_t        mp[$];
  int          cyc = 0;
  bit          m_push, m_pop;
  cmd_t        m_cmd;
  logic        m_out_valid = 1'b0;
  logic        m_res_valid = 1'b0;
  logic [7:0]  m_first = '0, m_second = '0;
  logic [1:0]  m_op = '0;
  logic [15:0] m_res = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mp.delete();
      m_out_valid = 1'b0;
      m_res_valid = 1'b0;
      m_first     = '0;
      m_second    = '0;
      m_op        = '0;
      m_res       = '0;
    end else begin
      cyc++;
      m_push = bus.in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && bus.issue_en;
      m_res_valid = 1'b0;
      if (mp.size() > 0 && mp[0].due == cyc) begin
        m_res_valid = 1'b1;
        m_res       = mp[0].val;
        void'(mp.pop_front());
      end
      m_out_valid = m_pop;
      if (m_pop) begin
        m_cmd    = mq.pop_front();
        m_first  = m_cmd.a;
        m_second = m_cmd.b;
        m_op     = m_cmd.op;
        mp.push_back('{cyc + 2, calc_fn(m_cmd.a, m_cmd.b, m_cmd.op)});
      end
      if (m_push) mq.push_back('{bus.in_first, bus.in_second, bus.in_op});
    end
  end

  always @(negedge clk) begin
    chk("in_ready",   bus.in_ready,   (mq.size() < DEPTH));
    chk("count",      bus.count,      mq.size());
    chk("out_valid",  bus.out_valid,  m_out_valid);
    chk("first_num",  bus.first_num,  m_first);
    chk("second_num", bus.second_num, m_second);
    chk("operation",  bus.operation,  m_op);
    chk("res_valid",  bus.res_valid,  m_res_valid);
    chk("res_data",   bus.res_data,   m_res);
  end

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.in_first  = a;
    bus.in_second = b;
    bus.in_op     = op;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [15:0] exp);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.res_valid) break;
    end
    chk({name, "_strobe"}, bus.res_valid, 1'b1);
    chk(name, bus.res_data, exp);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_first  = '0;
    bus.in_second = '0;
    bus.in_op     = '0;
    bus.issue_en  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_count",     bus.count,     0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_first",     bus.first_num, 0);
    chk("rst_res_data",  bus.res_data,  0);
    reset = 1'b1;

    // 1: single command, latency check
    bus.issue_en = 1'b1;
    push_cmd(8'd220, 8'd100, 2'd0);
    @(negedge clk);
    chk("t1_out_valid", bus.out_valid,  1);
    chk("t1_first",     bus.first_num,  220);
    chk("t1_second",    bus.second_num, 100);
    chk("t1_op",        bus.operation,  0);
    wait_res("t1_res", 16'd320);

    // 2: fill, overflow push ignored, drain in order
    bus.issue_en = 1'b0;
    push_cmd(8'd211, 8'd200, 2'd1);
    push_cmd(8'd200, 8'd200, 2'd2);
    push_cmd(8'd5,   8'd3,   2'd0);
    push_cmd(8'd1,   8'd1,   2'd3);
    chk("t2_count_full", bus.count,    4);
    chk("t2_in_ready",   bus.in_ready, 0);
    push_cmd(8'd9, 8'd9, 2'd0);
    chk("t2_count_after_ovf", bus.count, 4);
    bus.issue_en = 1'b1;
    wait_res("t2_res0", 16'd11);
    wait_res("t2_res1", 16'd40000);
    wait_res("t2_res2", 16'd8);
    wait_res("t2_res3", 16'd0);

    // 3: full queue with push and issue on the same edge
    bus.issue_en = 1'b0;
    for (int i = 0; i < 4; i++)
      push_cmd(8'($urandom), 8'($urandom), 2'($urandom));
    chk("t3_count_full", bus.count, 4);
    bus.in_first  = 8'd7;
    bus.in_second = 8'd6;
    bus.in_op     = 2'd2;
    bus.in_valid  = 1'b1;
    bus.issue_en  = 1'b1;
    @(negedge clk);
    chk("t3_count_a", bus.count, 3);
    @(negedge clk);
    chk("t3_count_b", bus.count, 3);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);

    // 4: pointer wrap with toggling issue_en, then random traffic
    for (int i = 0; i < 6; i++) begin
      bus.in_first  = 8'($urandom);
      bus.in_second = 8'($urandom);
      bus.in_op     = 2'($urandom);
      bus.in_valid  = 1'b1;
      bus.issue_en  = (i % 2 == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.issue_en = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      bus.in_first  = 8'($urandom);
      bus.in_second = 8'($urandom);
      bus.in_op     = 2'($urandom);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.issue_en  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.issue_en = 1'b1;
    repeat (10) @(negedge clk);

    // 5: asynchronous reset between issue and result
    push_cmd(8'd50, 8'd60, 2'd2);
    for (int n = 0; n < 10; n++) begin
      if (bus.out_valid) break;
      @(negedge clk);
    end
    chk("t5_issued", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_out_valid", bus.out_valid,  0);
    chk("t5_res_valid", bus.res_valid,  0);
    chk("t5_first",     bus.first_num,  0);
    chk("t5_second",    bus.second_num, 0);
    chk("t5_op",        bus.operation,  0);
    chk("t5_res_data",  bus.res_data,   0);
    chk("t5_count",     bus.count,      0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_res", bus.res_valid, 0);
    end
    chk("t5_count_after", bus.count,    0);
    chk("t5_ready_after", bus.in_ready, 1);

    // 6: idle issue_en on an empty queue holds outputs
    bus.issue_en = 1'b0;
    push_cmd(8'd9, 8'd4, 2'd2);
    bus.issue_en = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_out_valid", bus.out_valid,  0);
      chk("t6_res_valid", bus.res_valid,  0);
      chk("t6_first",     bus.first_num,  9);
      chk("t6_second",    bus.second_num, 4);
      chk("t6_op",        bus.operation,  2);
      chk("t6_res_data",  bus.res_data,   36);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
